song_reader: RTL

Note sequencer in the song-player path, directly downstream of the `mcu` song-select controller. It consumes `play`, `reset_player` and `song` from `mcu` and walks the selected song's note list in an external synchronous song ROM. For each note it hands note and duration to the note player and waits for that note to finish. At end of song it returns `song_done` to `mcu`.

---
 rtl/player_pkg.sv | 21 ++
 rtl/song_reader.sv | 128 ++++++++++++
 2 files changed

// File: rtl/player_pkg.sv
// Shared widths, state encoding and constants for the song-player path.
package player_pkg;

  localparam int IDX_W  = 5;
  localparam int SONG_W = 2;
  localparam int NOTE_W = 6;
  localparam int DUR_W  = 6;

  // A ROM entry with this duration terminates the song.
  localparam logic [DUR_W-1:0] END_DUR = '0;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_ISSUE     = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_NEXT      = 3'd4,
    S_DONE      = 3'd5
  } sr_state_t;

endpackage

// File: rtl/song_reader.sv
// Note sequencer: walks a song's note list in the external song ROM, hands each
// note to the note player, waits for it to expire and reports end of song.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | stopped at idx 0, waiting for play
// FETCH     | ROM word for {song, idx} valid; latch it or detect end
// ISSUE     | new_note pulse, note/duration valid
// WAIT_DONE | note playing; waits for note_done (or the sticky done_pend)
// NEXT      | advance idx, or finish after the last table entry
// DONE      | song_done pulse, idx cleared
module song_reader
  import player_pkg::*;
#(
  parameter int IDX_W  = player_pkg::IDX_W,
  parameter int SONG_W = player_pkg::SONG_W,
  parameter int NOTE_W = player_pkg::NOTE_W,
  parameter int DUR_W  = player_pkg::DUR_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     play,
  input  logic                     reset_player,
  input  logic [SONG_W-1:0]        song,
  input  logic                     note_done,
  input  logic [NOTE_W+DUR_W-1:0]  rom_data,
  output logic [SONG_W+IDX_W-1:0]  rom_addr,
  output logic                     new_note,
  output logic [NOTE_W-1:0]        note,
  output logic [DUR_W-1:0]         duration,
  output logic                     song_done
);

  sr_state_t          state, state_nxt;
  logic [IDX_W-1:0]   idx, idx_nxt;
  logic               done_pend, pend_nxt;
  logic [NOTE_W-1:0]  note_nxt;
  logic [DUR_W-1:0]   dur_nxt;
  logic [NOTE_W-1:0]  rom_note;
  logic [DUR_W-1:0]   rom_dur;

  assign rom_note = rom_data[NOTE_W+DUR_W-1:DUR_W];
  assign rom_dur  = rom_data[DUR_W-1:0];

  // The ROM registers its address, so present the index the FSM is about to
  // hold; the word for the new idx is then valid in the following FETCH.
  assign rom_addr = {song, idx_nxt};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      idx       <= '0;
      done_pend <= 1'b0;
      note      <= '0;
      duration  <= '0;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      done_pend <= pend_nxt;
      note      <= note_nxt;
      duration  <= dur_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    pend_nxt  = done_pend;
    note_nxt  = note;
    dur_nxt   = duration;
    new_note  = 1'b0;
    song_done = 1'b0;
    if (reset_player) begin
      state_nxt = S_IDLE;
      idx_nxt   = '0;
      pend_nxt  = 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (play) state_nxt = S_FETCH;
        end
        S_FETCH: begin
          if (play) begin
            if (rom_dur == DUR_W'(END_DUR)) begin
              state_nxt = S_DONE;
            end else begin
              note_nxt  = rom_note;
              dur_nxt   = rom_dur;
              state_nxt = S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          // Gated by play so a pause here cannot stretch the pulse.
          if (play) begin
            new_note  = 1'b1;
            state_nxt = S_WAIT_DONE;
          end
        end
        S_WAIT_DONE: begin
          if (!play) begin
            if (note_done) pend_nxt = 1'b1;
          end else if (note_done || done_pend) begin
            pend_nxt  = 1'b0;
            state_nxt = S_NEXT;
          end
        end
        S_NEXT: begin
          if (play) begin
            if (idx == '1) begin
              state_nxt = S_DONE;
            end else begin
              idx_nxt   = idx + IDX_W'(1);
              state_nxt = S_FETCH;
            end
          end
        end
        S_DONE: begin
          song_done = 1'b1;
          idx_nxt   = '0;
          state_nxt = S_IDLE;
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

endmodule
